// File: rtl/isolde_decoder_pkg.sv
// -----------------------------------------------------------------------------
// isolde_decoder_pkg
// Shared definitions between the ISOLDE instruction batcher (fetch side) and
// the ISOLDE custom-instruction decoder, so that both ends agree on one
// instruction-length table.
//   ISOLDE_MAX_WORDS    : batch depth in 32-bit words (fixed at 5)
//   isolde_batch_t      : five-word batch, [0] is the first fetched word
//   isolde_instr_words(): word count of an instruction from its first word,
//                         0 for an unknown ISOLDE encoding
// -----------------------------------------------------------------------------
package isolde_decoder_pkg;

   localparam int unsigned ISOLDE_MAX_WORDS = 5;

   typedef logic [ISOLDE_MAX_WORDS-1:0][31:0] isolde_batch_t;

   // ISOLDE instructions live in the custom-0 major opcode; func7 selects
   // the operation.
   localparam logic [6:0] ISOLDE_OPCODE      = 7'b000_1011;
   localparam logic [6:0] ISOLDE_F7_GEMM     = 7'h01;
   localparam logic [6:0] ISOLDE_F7_REDMULE  = 7'h02;
   localparam logic [6:0] ISOLDE_F7_VLE32_4  = 7'h03;

   function automatic logic [2:0] isolde_instr_words(input logic [31:0] word0);
      logic [2:0] words;
      if (word0[6:0] != ISOLDE_OPCODE) begin
         words = 3'd1;
      end else begin
         case (word0[31:25])
            ISOLDE_F7_GEMM:    words = 3'd2;
            ISOLDE_F7_REDMULE: words = 3'd4;
            ISOLDE_F7_VLE32_4: words = 3'd5;
            default:           words = 3'd0;
         endcase
      end
      return words;
   endfunction

endpackage

// File: rtl/isolde_instr_batcher_if.sv
// -----------------------------------------------------------------------------
// isolde_instr_batcher_if
// Bundles the prefetch-side word stream and the decoder-side batch handshake.
//   fetch_valid_i / fetch_rdata_i / fetch_ready_o : one 32-bit word per beat
//   flush_i                                       : drop buffered words
//   batch_valid_o / batch_o / batch_len_o /
//   batch_illegal_o / batch_ready_i               : batch to the decoder
// Modports:
//   master : the batcher (drives fetch_ready_o and all batch_* outputs)
//   slave  : the surrounding pipeline (prefetch buffer + decoder)
// -----------------------------------------------------------------------------
interface isolde_instr_batcher_if
   import isolde_decoder_pkg::*;
();
   logic          fetch_valid_i;
   logic [31:0]   fetch_rdata_i;
   logic          fetch_ready_o;
   logic          flush_i;
   logic          batch_valid_o;
   isolde_batch_t batch_o;
   logic [2:0]    batch_len_o;
   logic          batch_illegal_o;
   logic          batch_ready_i;

   modport master (
      input  fetch_valid_i, fetch_rdata_i, flush_i, batch_ready_i,
      output fetch_ready_o, batch_valid_o, batch_o, batch_len_o, batch_illegal_o
   );

   modport slave (
      output fetch_valid_i, fetch_rdata_i, flush_i, batch_ready_i,
      input  fetch_ready_o, batch_valid_o, batch_o, batch_len_o, batch_illegal_o
   );
endinterface

// File: rtl/isolde_batch_skid.sv
// -----------------------------------------------------------------------------
// isolde_batch_skid
// One-entry valid/data register that parks the next fetch word while the
// batcher holds a complete batch. Only built when ISOLDE_BATCH_SKID_EN is
// defined; otherwise this file contributes nothing.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : synchronous clear (flush), wins over push
//   push_i/data_i : park a word
//   pop_i         : release the parked word
//   valid_o/data_o: parked word
// -----------------------------------------------------------------------------
`ifdef ISOLDE_BATCH_SKID_EN
module isolde_batch_skid (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clr_i,
   input  logic        push_i,
   input  logic        pop_i,
   input  logic [31:0] data_i,
   output logic        valid_o,
   output logic [31:0] data_o
);
   logic        valid_q, valid_d;
   logic [31:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (clr_i) begin
         valid_d = 1'b0;
         data_d  = '0;
      end else if (push_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (pop_i) begin
         valid_d = 1'b0;
         data_d  = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
endmodule
`endif

// File: rtl/isolde_instr_batcher.sv
// -----------------------------------------------------------------------------
// isolde_instr_batcher
// Collects 1..5 prefetched 32-bit words into one ISOLDE instruction batch
// and presents it to the decoder with a valid/ready handshake. The first
// word of each instruction determines its length via isolde_instr_words().
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : isolde_instr_batcher_if.master (fetch stream in, batch out)
// Configuration:
//   ISOLDE_BATCH_SKID_EN : adds a one-word skid register so the next word is
//                          accepted while a batch is held, giving one 1-word
//                          instruction per cycle.
// -----------------------------------------------------------------------------
module isolde_instr_batcher
   import isolde_decoder_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   rst_ni,
   isolde_instr_batcher_if.master bus
);
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_HOLD    = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [2:0]    len_q, len_d;
   isolde_batch_t slots_q, slots_d;
   logic          illegal_q, illegal_d;

   logic          fetch_ready;
   logic          fetch_acc;
   logic          batch_hs;
   logic          start_new;
   logic [31:0]   start_word;
   logic [2:0]    start_len;

`ifdef ISOLDE_BATCH_SKID_EN
   logic          skid_valid;
   logic [31:0]   skid_data;
   logic          skid_push;
   logic          skid_pop;

   isolde_batch_skid u_skid (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr_i   (bus.flush_i),
      .push_i  (skid_push),
      .pop_i   (skid_pop),
      .data_i  (bus.fetch_rdata_i),
      .valid_o (skid_valid),
      .data_o  (skid_data)
   );

   assign fetch_ready = (state_q == S_HOLD) ? ~skid_valid : 1'b1;
`else
   assign fetch_ready = (state_q != S_HOLD);
`endif

   assign fetch_acc = bus.fetch_valid_i & fetch_ready;
   assign batch_hs  = (state_q == S_HOLD) & bus.batch_ready_i;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      slots_d    = slots_q;
      illegal_d  = illegal_q;
      start_new  = 1'b0;
      start_word = '0;
`ifdef ISOLDE_BATCH_SKID_EN
      skid_push  = 1'b0;
      skid_pop   = 1'b0;
`endif

      case (state_q)
         S_IDLE: begin
            if (fetch_acc) begin
               start_new  = 1'b1;
               start_word = bus.fetch_rdata_i;
            end
         end
         S_COLLECT: begin
            if (fetch_acc) begin
               slots_d[cnt_q] = bus.fetch_rdata_i;
               cnt_d          = cnt_q + 3'd1;
               if (cnt_q + 3'd1 == len_q) state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (batch_hs) begin
               state_d   = S_IDLE;
               cnt_d     = '0;
               len_d     = '0;
               slots_d   = '0;
               illegal_d = 1'b0;
`ifdef ISOLDE_BATCH_SKID_EN
               // The parked word (or a word arriving right now while the skid
               // is empty) becomes slot 0 of the next instruction.
               if (skid_valid) begin
                  start_new  = 1'b1;
                  start_word = skid_data;
                  skid_pop   = 1'b1;
               end else if (fetch_acc) begin
                  start_new  = 1'b1;
                  start_word = bus.fetch_rdata_i;
               end
            end else if (fetch_acc) begin
               skid_push = 1'b1;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase

      // First word of a new instruction: decode length, open the batch.
      start_len = isolde_instr_words(start_word);
      if (start_new) begin
         slots_d    = '0;
         slots_d[0] = start_word;
         cnt_d      = 3'd1;
         if (start_len == 3'd0) begin
            // Unknown ISOLDE encoding: close as a 1-word illegal batch.
            len_d     = 3'd1;
            illegal_d = 1'b1;
            state_d   = S_HOLD;
         end else begin
            len_d     = start_len;
            illegal_d = 1'b0;
            state_d   = (start_len == 3'd1) ? S_HOLD : S_COLLECT;
         end
      end

      // Flush drops everything, including a word accepted this cycle.
      if (bus.flush_i) begin
         state_d   = S_IDLE;
         cnt_d     = '0;
         len_d     = '0;
         slots_d   = '0;
         illegal_d = 1'b0;
`ifdef ISOLDE_BATCH_SKID_EN
         skid_push = 1'b0;
         skid_pop  = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         len_q     <= '0;
         slots_q   <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         len_q     <= len_d;
         slots_q   <= slots_d;
         illegal_q <= illegal_d;
      end
   end

   assign bus.fetch_ready_o   = fetch_ready;
   assign bus.batch_valid_o   = (state_q == S_HOLD);
   assign bus.batch_o         = slots_q;
   assign bus.batch_len_o     = len_q;
   assign bus.batch_illegal_o = illegal_q;

endmodule

// File: tb/tb_isolde_instr_batcher.sv
// -----------------------------------------------------------------------------
// tb_isolde_instr_batcher
// Directed scenarios plus a randomized instruction stream checked against a
// word-queue / expected-batch reference model.
// -----------------------------------------------------------------------------
module tb_isolde_instr_batcher;
   import isolde_decoder_pkg::*;

   logic clk    = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk = ~clk;

   isolde_instr_batcher_if bus ();

   isolde_instr_batcher dut (
      .clk_i  (clk),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   int checks   = 0;
   int failures = 0;

`ifdef ISOLDE_BATCH_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   typedef struct packed {
      logic [2:0]    len;
      logic          ill;
      isolde_batch_t w;
   } exp_t;

   // ---------------- helpers (stimulus only) ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.fetch_valid_i = 1'b0;
      bus.fetch_rdata_i = '0;
      bus.flush_i       = 1'b0;
      bus.batch_ready_i = 1'b0;
   endtask

   task automatic handshake();
      bus.batch_ready_i = 1'b1;
      step();
      bus.batch_ready_i = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      bus.fetch_valid_i = 1'b1;
      bus.fetch_rdata_i = w;
      step();
      bus.fetch_valid_i = 1'b0;
   endtask

   // Instruction length rule: non-ISOLDE opcode 1 word; ISOLDE gemm 2,
   // redmule_gemm 4, vle32_4 5, anything else 0 (illegal).
   function automatic int ref_len(input logic [31:0] w);
      if (w[6:0] != 7'h0B) return 1;
      if (w[31:25] == 7'h01) return 2;
      if (w[31:25] == 7'h02) return 4;
      if (w[31:25] == 7'h03) return 5;
      return 0;
   endfunction

   function automatic logic [31:0] mk_hdr(input logic [6:0] f7);
      logic [31:0] w;
      w        = $urandom;
      w[6:0]   = 7'h0B;
      w[31:25] = f7;
      return w;
   endfunction

   function automatic logic [31:0] mk_plain();
      logic [31:0] w;
      w = $urandom;
      if (w[6:0] == 7'h0B) w[6:0] = 7'h33;
      return w;
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle_inputs();
      rst_ni = 1'b0;
      #12;
      checks++; if (bus.batch_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.batch_valid_o); end
      checks++; if (bus.batch_o !== '0) begin failures++; $display("FAIL reset_batch got=%h exp=0", bus.batch_o); end
      checks++; if (bus.batch_len_o !== 3'd0) begin failures++; $display("FAIL reset_len got=%0d exp=0", bus.batch_len_o); end
      checks++; if (bus.batch_illegal_o !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b exp=0", bus.batch_illegal_o); end
      checks++; if (bus.fetch_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.fetch_ready_o); end
      @(negedge clk);
      rst_ni = 1'b1;
      step();
      checks++; if (bus.fetch_ready_o !== 1'b1 || bus.batch_valid_o !== 1'b0) begin failures++; $display("FAIL post_reset ready=%b valid=%b exp ready=1 valid=0", bus.fetch_ready_o, bus.batch_valid_o); end
   endtask

   task automatic test_redmule();
      logic [31:0]   w [4];
      isolde_batch_t held;
      w[0] = mk_hdr(7'h02); w[1] = 32'h11; w[2] = 32'h22; w[3] = 32'h33;
      for (int i = 0; i < 4; i++) begin
         bus.fetch_valid_i = 1'b1;
         bus.fetch_rdata_i = w[i];
         step();
         if (i < 3) begin
            checks++; if (bus.batch_valid_o !== 1'b0) begin failures++; $display("FAIL redmule_early_valid word=%0d got=%b exp=0", i, bus.batch_valid_o); end
         end
      end
      bus.fetch_valid_i = 1'b0;
      checks++; if (bus.batch_valid_o !== 1'b1) begin failures++; $display("FAIL redmule_valid got=%b exp=1", bus.batch_valid_o); end
      checks++; if (bus.batch_len_o !== 3'd4) begin failures++; $display("FAIL redmule_len got=%0d exp=4", bus.batch_len_o); end
      checks++; if (bus.batch_illegal_o !== 1'b0) begin failures++; $display("FAIL redmule_illegal got=%b exp=0", bus.batch_illegal_o); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (bus.batch_o[i] !== w[i]) begin failures++; $display("FAIL redmule_slot%0d got=%h exp=%h", i, bus.batch_o[i], w[i]); end
      end
      checks++; if (bus.batch_o[4] !== 32'h0) begin failures++; $display("FAIL redmule_slot4 got=%h exp=0", bus.batch_o[4]); end
      checks++; if (bus.fetch_ready_o !== SKID) begin failures++; $display("FAIL redmule_ready_hold got=%b exp=%b", bus.fetch_ready_o, SKID); end
      held = bus.batch_o;
      step(); step();
      checks++; if (bus.batch_valid_o !== 1'b1 || bus.batch_o !== held || bus.batch_len_o !== 3'd4) begin failures++; $display("FAIL redmule_stable valid=%b len=%0d batch=%h exp valid=1 len=4 batch=%h", bus.batch_valid_o, bus.batch_len_o, bus.batch_o, held); end
      checks++; if (bus.fetch_ready_o !== SKID) begin failures++; $display("FAIL redmule_ready_wait got=%b exp=%b", bus.fetch_ready_o, SKID); end
      handshake();
      checks++; if (bus.batch_valid_o !== 1'b0 || bus.batch_o !== '0 || bus.fetch_ready_o !== 1'b1) begin failures++; $display("FAIL redmule_release valid=%b ready=%b batch=%h exp valid=0 ready=1 batch=0", bus.batch_valid_o, bus.fetch_ready_o, bus.batch_o); end
   endtask

   task automatic test_illegal();
      logic [31:0] hdr, p;
      hdr = mk_hdr(7'h55);
      send_word(hdr);
      checks++; if (bus.batch_valid_o !== 1'b1 || bus.batch_len_o !== 3'd1 || bus.batch_illegal_o !== 1'b1) begin failures++; $display("FAIL illegal_batch valid=%b len=%0d ill=%b exp 1/1/1", bus.batch_valid_o, bus.batch_len_o, bus.batch_illegal_o); end
      checks++; if (bus.batch_o[0] !== hdr || bus.batch_o[4:1] !== '0) begin failures++; $display("FAIL illegal_slots got=%h exp slot0=%h rest 0", bus.batch_o, hdr); end
      checks++; if (bus.fetch_ready_o !== SKID) begin failures++; $display("FAIL illegal_ready got=%b exp=%b", bus.fetch_ready_o, SKID); end
      handshake();
      p = mk_plain();
      send_word(p);
      checks++; if (bus.batch_valid_o !== 1'b1 || bus.batch_len_o !== 3'd1 || bus.batch_illegal_o !== 1'b0 || bus.batch_o[0] !== p) begin failures++; $display("FAIL illegal_next valid=%b len=%0d ill=%b w0=%h exp 1/1/0/%h", bus.batch_valid_o, bus.batch_len_o, bus.batch_illegal_o, bus.batch_o[0], p); end
      handshake();
   endtask

   task automatic test_vle_gaps();
      isolde_batch_t e;
      e    = '0;
      e[0] = mk_hdr(7'h03);
      for (int i = 1; i < 5; i++) e[i] = $urandom;
      for (int i = 0; i < 3; i++) begin
         bus.fetch_valid_i = 1'b1;
         bus.fetch_rdata_i = e[i];
         step();
      end
      bus.fetch_valid_i = 1'b0;
      bus.fetch_rdata_i = $urandom;
      step(); step(); step();
      checks++; if (bus.batch_valid_o !== 1'b0 || bus.batch_o[2:0] !== e[2:0]) begin failures++; $display("FAIL vle_gap_hold valid=%b slots=%h exp valid=0 slots=%h", bus.batch_valid_o, bus.batch_o[2:0], e[2:0]); end
      for (int i = 3; i < 5; i++) begin
         bus.fetch_valid_i = 1'b1;
         bus.fetch_rdata_i = e[i];
         step();
      end
      bus.fetch_valid_i = 1'b0;
      checks++; if (bus.batch_valid_o !== 1'b1 || bus.batch_len_o !== 3'd5) begin failures++; $display("FAIL vle_len valid=%b len=%0d exp valid=1 len=5", bus.batch_valid_o, bus.batch_len_o); end
      checks++; if (bus.batch_o[4] !== e[4]) begin failures++; $display("FAIL vle_last got=%h exp=%h", bus.batch_o[4], e[4]); end
      checks++; if (bus.batch_o !== e) begin failures++; $display("FAIL vle_batch got=%h exp=%h", bus.batch_o, e); end
      handshake();
   endtask

   task automatic test_flush();
      isolde_batch_t e;
      logic [31:0]   p;
      send_word(mk_hdr(7'h01));
      bus.fetch_valid_i = 1'b1;
      bus.fetch_rdata_i = $urandom;
      bus.flush_i       = 1'b1;
      step();
      bus.flush_i       = 1'b0;
      bus.fetch_valid_i = 1'b0;
      checks++; if (bus.batch_valid_o !== 1'b0 || bus.batch_o !== '0 || bus.fetch_ready_o !== 1'b1) begin failures++; $display("FAIL flush_clear valid=%b ready=%b batch=%h exp 0/1/0", bus.batch_valid_o, bus.fetch_ready_o, bus.batch_o); end
      p    = mk_plain();
      e    = '0;
      e[0] = p;
      send_word(p);
      checks++; if (bus.batch_valid_o !== 1'b1 || bus.batch_len_o !== 3'd1) begin failures++; $display("FAIL flush_next valid=%b len=%0d exp 1/1", bus.batch_valid_o, bus.batch_len_o); end
      checks++; if (bus.batch_o !== e) begin failures++; $display("FAIL flush_stale got=%h exp=%h", bus.batch_o, e); end
      handshake();
   endtask

   task automatic test_async_reset();
      send_word(mk_hdr(7'h02));
      #3;
      rst_ni = 1'b0;
      #1;
      checks++; if (bus.batch_o !== '0 || bus.batch_len_o !== 3'd0 || bus.batch_valid_o !== 1'b0 || bus.fetch_ready_o !== 1'b1) begin failures++; $display("FAIL async_reset batch=%h len=%0d valid=%b ready=%b exp 0/0/0/1", bus.batch_o, bus.batch_len_o, bus.batch_valid_o, bus.fetch_ready_o); end
      @(negedge clk);
      rst_ni = 1'b1;
      step();
   endtask

   task automatic test_back_to_back();
      logic [31:0] w [3];
      logic        rec_v [8];
      logic [31:0] rec_d [8];
      logic        rdy, exp_v;
      int          idx, outn;
      for (int i = 0; i < 3; i++) w[i] = mk_plain();
      idx = 0;
      bus.batch_ready_i = 1'b1;
      for (int c = 0; c < 8; c++) begin
         bus.fetch_valid_i = (idx < 3);
         bus.fetch_rdata_i = (idx < 3) ? w[idx] : 32'h0;
         rdy = bus.fetch_ready_o;
         step();
         if (bus.fetch_valid_i && rdy) idx++;
         rec_v[c] = bus.batch_valid_o;
         rec_d[c] = bus.batch_o[0];
      end
      bus.fetch_valid_i = 1'b0;
      bus.batch_ready_i = 1'b0;
      outn = 0;
      for (int c = 0; c < 8; c++) begin
         exp_v = SKID ? (c < 3) : ((c % 2 == 0) && (c < 6));
         checks++; if (rec_v[c] !== exp_v) begin failures++; $display("FAIL b2b_valid cycle=%0d got=%b exp=%b", c, rec_v[c], exp_v); end
         if (rec_v[c] === 1'b1 && outn < 3) begin
            checks++; if (rec_d[c] !== w[outn]) begin failures++; $display("FAIL b2b_data cycle=%0d got=%h exp=%h", c, rec_d[c], w[outn]); end
            outn++;
         end
      end
      step();
   endtask

   task automatic test_random();
      exp_t        exp_q[$];
      logic [31:0] wq[$];
      exp_t        e;
      logic [31:0] hdr;
      logic [6:0]  f7;
      int          n, kind, cyc;
      logic        bv, br, fv, rdy;
      for (int k = 0; k < 40; k++) begin
         kind = $urandom_range(0, 4);
         case (kind)
            0:       hdr = mk_plain();
            1:       hdr = mk_hdr(7'h01);
            2:       hdr = mk_hdr(7'h02);
            3:       hdr = mk_hdr(7'h03);
            default: begin f7 = 7'($urandom_range(4, 127)); hdr = mk_hdr(f7); end
         endcase
         n      = ref_len(hdr);
         e      = '0;
         e.w[0] = hdr;
         e.ill  = (n == 0);
         if (n == 0) n = 1;
         e.len  = 3'(n);
         wq.push_back(hdr);
         for (int j = 1; j < n; j++) begin
            e.w[j] = $urandom;
            wq.push_back(e.w[j]);
         end
         exp_q.push_back(e);
      end
      cyc = 0;
      while ((exp_q.size() > 0) && (cyc < 3000)) begin
         bv = bus.batch_valid_o;
         br = ($urandom_range(0, 3) != 0);
         if (bv && br) begin
            if (exp_q.size() == 0) begin
               checks++; failures++; $display("FAIL rand_extra_batch got=%h exp none", bus.batch_o);
            end else begin
               e = exp_q.pop_front();
               checks++; if (bus.batch_len_o !== e.len || bus.batch_illegal_o !== e.ill || bus.batch_o !== e.w) begin failures++; $display("FAIL rand_batch len=%0d ill=%b w=%h exp len=%0d ill=%b w=%h", bus.batch_len_o, bus.batch_illegal_o, bus.batch_o, e.len, e.ill, e.w); end
            end
         end
         fv = (wq.size() > 0) && ($urandom_range(0, 3) != 0);
         bus.batch_ready_i = br;
         bus.fetch_valid_i = fv;
         bus.fetch_rdata_i = fv ? wq[0] : 32'h0;
         rdy = bus.fetch_ready_o;
         step();
         if (fv && rdy) void'(wq.pop_front());
         cyc++;
      end
      idle_inputs();
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rand_timeout remaining=%0d exp=0", exp_q.size()); end
      step();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_redmule();
      test_illegal();
      test_vle_gaps();
      test_flush();
      test_async_reset();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/isolde_instr_batcher.md
# isolde_instr_batcher

Fetch-side producer for the ISOLDE variable-length instruction batch consumed by the ISOLDE custom-instruction decoder. Accepts 32-bit instruction words one per cycle from the prefetch stream and determines instruction length from the first word. Collects 1–5 words into a five-word batch and presents it to the decoder with a valid/ready handshake. Sits between the IF-stage prefetch buffer and the IF-ID pipeline registers.

## Interface
- MaxWords, 5, batch depth in 32-bit words; fixed, not overridable.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- fetch_valid_i  in  1  fetch word available.
- fetch_rdata_i  in  32  fetch word.
- fetch_ready_o  out  1  word accepted when valid and ready are both high.
- flush_i  in  1  synchronous flush (branch/exception); drops all buffered words.
- batch_valid_o  out  1  complete batch held.
- batch_o  out  5x32  batch words; [0] first fetched, [i] i-th in fetch order; unused entries zero.
- batch_len_o  out  3  word count of held instruction, 1..5.
- batch_illegal_o  out  1  first word carries an unknown ISOLDE encoding.
- batch_ready_i  in  1  decoder accepts batch.

## Operation
- Length decode: isolde_instr_words(word0) from the shared package.
  - Non-ISOLDE 32-bit → 1.
  - gemm → 2.
  - redmule_gemm → 4.
  - vle32_4 → 5.
  - Invalid ISOLDE encoding → 0.
- Length 0: batch is closed immediately with batch_len_o=1 and batch_illegal_o=1; no further words are consumed for it.
- FSM states:
  - IDLE: fetch_ready_o=1. On accept: store word in slot 0 and latch length L.
    - If L≤1 → HOLD.
    - Otherwise → COLLECT with cnt=1.
  - COLLECT: fetch_ready_o=1. On accept: store word in slot cnt and increment cnt. When cnt reaches L → HOLD.
  - HOLD: batch_valid_o=1; fetch_ready_o=0 (see Configuration). On batch_ready_i → IDLE; all slots are cleared to zero in the same edge.
- Counter cnt is 3 bits. It never exceeds 5 and has no wrap.
- flush_i in any state:
  - Next state is IDLE; cnt, slots, len and illegal are cleared; skid is emptied.
  - A fetch word accepted in the flush cycle is discarded.
  - A batch handshake in the flush cycle is still counted as delivered by the decoder; the batcher does not re-present it.
- fetch_valid_i low in COLLECT: hold state and all slots indefinitely; no timeout.

## Timing
- Reset values: batch_valid_o=0, batch_o=0, batch_len_o=0, batch_illegal_o=0, fetch_ready_o=1 (state IDLE).
- fetch_ready_o is combinational from state and skid occupancy only, never from fetch_valid_i.
- batch_* outputs are registered.
- For an L-word instruction with back-to-back words, batch_valid_o rises on the clock edge of the L-th accept (visible the following cycle).
- batch_valid_o stays high with stable batch_o, batch_len_o and batch_illegal_o until batch_ready_i or flush_i.
- Throughput without skid: one instruction every L+1 cycles.
- Reset asserted mid-collection clears everything asynchronously. Operation resumes in IDLE on the first edge after deassertion.

## Configuration
- ISOLDE_BATCH_SKID_EN defined:
  - A one-word skid register is added.
  - In HOLD, fetch_ready_o = skid empty; one next word is accepted and parked.
  - On batch handshake, the skid word is loaded as slot 0 of the next instruction in the same edge. Its length is decoded; next state is HOLD if L≤1, else COLLECT with cnt=1.
  - Back-to-back 1-word instructions sustain one per cycle after the first.
- ISOLDE_BATCH_SKID_EN undefined: no skid register; fetch_ready_o=0 in HOLD.

## Structure
- isolde_decoder_pkg:
  - isolde_instr_words() function, shared with the decoder so both ends use one length table.
  - Batch type isolde_batch_t (logic [4:0][31:0]).
  - Constant ISOLDE_MAX_WORDS=5.
- Batcher FSM state enum stays local.
- Sub-module: isolde_batch_skid (one-entry valid/data register); instantiated only under ISOLDE_BATCH_SKID_EN.

## Test plan
- Reset:
  - Stimulus: hold rst_ni=0, then release.
  - Required: all outputs at reset values; fetch_ready_o=1.
- redmule_gemm:
  - Stimulus: header, then 32'h11, 32'h22, 32'h33 on consecutive cycles, batch_ready_i=0.
  - Required: batch_valid_o=1 after 4th accept; batch_len_o=4; batch_o[1..3]=11/22/33; batch_o[4]=0; fetch_ready_o=0 until batch_ready_i pulse.
- Illegal encoding:
  - Stimulus: ISOLDE opcode with unknown func7.
  - Required: batch_len_o=1 and batch_illegal_o=1 one cycle later; next fetch word starts a new batch.
- vle32_4 with gaps:
  - Stimulus: five words with fetch_valid_i low for 3 cycles between words 2 and 3.
  - Required: slots preserved; batch_len_o=5; batch_o[4] equals the last word.
- Flush mid-gemm:
  - Stimulus: flush_i after word 0, then a 1-word instruction.
  - Required: batch_len_o=1; batch_o[0] is the new word; no stale gemm data in batch_o.
- With ISOLDE_BATCH_SKID_EN:
  - Stimulus: three 1-word instructions back-to-back, batch_ready_i=1.
  - Required: batch_valid_o high for 3 consecutive cycles after the first, each batch_o[0] matching in order.
- Without ISOLDE_BATCH_SKID_EN:
  - Stimulus: same three 1-word instructions.
  - Required: one batch every 2 cycles.
